led_matrix_driver: RTL and testbench
====================================

Name: led_matrix_driver

Overview:
- Output-side counterpart of the sensor matrix scanner: drives the board's 8x8 per-square LED matrix by time-multiplexing rows through the external 3-to-8 row decoder and active-low column sinks.
- Accepts whole 64-bit frames (highlights, legal moves, errors) plus a blink mask over a valid/ready handshake.
- Double-buffered so frame updates never tear mid-scan.
- Square indexing matches the scanner's sensor_state: bit = row*8 + col.

Parameters:
- DWELL_CYCLES, 1000, clocks each row is driven (>=1)
- BLANK_CYCLES, 16, clocks of all-off blanking before each row, anti-ghosting (>=1)
- BLINK_FRAMES, 32, complete frames per blink half-period (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- enable  in  1  1 = scan display; 0 = blank and idle
- frame_data  in  64  LED on-map, bit row*8+col, 1 = lit
- blink_mask  in  64  1 = square blinks when lit
- frame_valid  in  1  frame_data/blink_mask valid
- frame_ready  out  1  pending buffer empty; accepts a frame
- row_addr  out  3  row address to external decoder
- row_addr_en  out  1  decoder enable, active-low
- col_out  out  8  column drive, active-low, bit c = column c
- frame_start  out  1  one-cycle pulse at the start of each frame (row 0 blank entry)

Behaviour:
- Reset values (async, rst_n=0):
  - row_addr=0, row_addr_en=1, col_out=8'hFF, frame_start=0, frame_ready=1.
  - Active and pending buffers cleared to 0; pending_full=0; blink_phase=0; frame and dwell counters 0; state=IDLE.
- All outputs are registered.
- Handshake:
  - A frame is accepted on a clk edge with frame_valid && frame_ready; it is captured into the pending buffer and pending_full is set.
  - frame_ready = ~pending_full.
  - A new frame offered while pending_full=1 is not taken; the source holds it.
- Promotion:
  - On every entry to BLANK with row 0 (from IDLE or on wrap), if pending_full=1: pending is copied to active and pending_full is cleared, so frame_ready rises the following cycle.
  - No accept can coincide with a promotion, since ready=0 while full.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE: row_addr_en=1, col_out=FF.
    - enable=1 sampled -> next cycle BLANK, row_addr=0, frame_start=1.
  - BLANK: row_addr_en=1, col_out=FF; lasts exactly BLANK_CYCLES cycles, then DRIVE.
    - row_addr changes only on entry to BLANK, never while row_addr_en=0.
  - DRIVE: row_addr_en=0; lasts exactly DWELL_CYCLES cycles.
    - col_out = ~(active_frame[row*8+:8] & ~(active_blink[row*8+:8] & {8{blink_phase}})).
    - At end: row increments; 7 wraps to 0, which is a frame boundary.
  - Row period = BLANK_CYCLES+DWELL_CYCLES; frame period = 8x that.
- Frame boundary (wrap to row 0):
  - frame_start=1 for that cycle only.
  - Frame counter increments; at BLINK_FRAMES it clears and blink_phase toggles.
- enable=0 sampled in BLANK or DRIVE -> next cycle IDLE with blank outputs.
  - Counters and row reset to 0, blink_phase holds.
  - The pending buffer is kept, and handshake acceptance continues in IDLE.
  - Re-enable always restarts at row 0.
- Counters are sized $clog2 of their parameter (min 1 bit); no overflow past terminal count.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> same cycle row_addr_en=1, col_out=FF, frame_ready=1, frame_start=0, row_addr=0; after release with enable=0, all outputs hold.
- Basic scan (DWELL=4, BLANK=2): load frame 64'h0000_0000_0000_0081, then enable=1.
  - Expect frame_start pulse, 2 cycles blank, then 4 cycles row_addr=0, row_addr_en=0, col_out=8'h7E.
  - Rows 1-7 show col_out=FF while driven.
  - frame_start repeats every 48 cycles.
- Backpressure: accept frame A (row2 = 8'hF0) while scanning, offer B immediately -> frame_ready=0, B not taken.
  - At next row-0 entry A goes active and ready rises one cycle later; B is then accepted.
  - Row 2 shows col_out=8'h0F only from that frame on; no mid-frame change.
- Blink (BLINK_FRAMES=2): frame 0x01, blink_mask 0x01 -> row 0 col_out=FE during frames 0-1, FF in frames 2-3, FE in frames 4-5.
- Enable drop: deassert enable during DRIVE of row 3 -> next cycle row_addr_en=1, col_out=FF. Re-enable -> frame_start, restart at row 0.
- Row-address stability: over 3 full frames, check row_addr never changes while row_addr_en=0, and each row's DRIVE is exactly DWELL_CYCLES.

Source files
------------

// File: rtl/led_matrix_driver.sv
// 8x8 per-square LED matrix driver: time-multiplexes rows through an external
// 3-to-8 decoder with active-low column sinks, double-buffered frames and blink.
module led_matrix_driver #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [63:0] frame_data,
  input  logic [63:0] blink_mask,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [2:0]  row_addr,
  output logic        row_addr_en,
  output logic [7:0]  col_out,
  output logic        frame_start
);

  localparam int unsigned PHASE_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned PW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYCLES - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] phase_cnt;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          pending_full;
  logic [63:0]   pending_frame;
  logic [63:0]   pending_blink;
  logic [63:0]   active_frame;
  logic [63:0]   active_blink;

  logic start_scan;
  logic wrap;
  logic row0_entry;

  // Column sinks for one row: lit squares pull low unless blinked off this phase.
  function automatic logic [7:0] row_cols(input logic [2:0]  row,
                                          input logic [63:0] frame,
                                          input logic [63:0] blink,
                                          input logic        phase);
    logic [7:0] lit;
    lit = frame[{row, 3'b000} +: 8] & ~(blink[{row, 3'b000} +: 8] & {8{phase}});
    return ~lit;
  endfunction

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    start_scan = 1'b0;
    wrap       = 1'b0;
    if (state == IDLE && enable) begin
      start_scan = 1'b1;
    end
    if (state == DRIVE && enable && phase_cnt == DWELL_LAST && row_addr == 3'd7) begin
      wrap = 1'b1;
    end
    row0_entry = start_scan | wrap;
  end

  // NOTE: the frame buffers are plain registers, so they take the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      frame_cnt     <= '0;
      blink_phase   <= 1'b0;
      pending_full  <= 1'b0;
      pending_frame <= '0;
      pending_blink <= '0;
      active_frame  <= '0;
      active_blink  <= '0;
      frame_ready   <= 1'b1;
      row_addr      <= 3'd0;
      row_addr_en   <= 1'b1;
      col_out       <= 8'hFF;
      frame_start   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      frame_start <= row0_entry;

      // Accept and promote are exclusive: ready is low whenever pending is full.
      if (frame_valid && frame_ready) begin
        pending_frame <= frame_data;
        pending_blink <= blink_mask;
        pending_full  <= 1'b1;
        frame_ready   <= 1'b0;
      end else if (row0_entry && pending_full) begin
        active_frame  <= pending_frame;
        active_blink  <= pending_blink;
        pending_full  <= 1'b0;
        frame_ready   <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state     <= BLANK;
            phase_cnt <= '0;
            row_addr  <= 3'd0;
          end
        end

        BLANK: begin
          if (!enable) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            frame_cnt   <= '0;
            row_addr    <= 3'd0;
            row_addr_en <= 1'b1;
            col_out     <= 8'hFF;
          end else if (phase_cnt == BLANK_LAST) begin
            state       <= DRIVE;
            phase_cnt   <= '0;
            row_addr_en <= 1'b0;
            col_out     <= row_cols(row_addr, active_frame, active_blink, blink_phase);
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        DRIVE: begin
          if (!enable) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            frame_cnt   <= '0;
            row_addr    <= 3'd0;
            row_addr_en <= 1'b1;
            col_out     <= 8'hFF;
          end else if (phase_cnt == DWELL_LAST) begin
            state       <= BLANK;
            phase_cnt   <= '0;
            row_addr    <= row_addr + 3'd1;
            row_addr_en <= 1'b1;
            col_out     <= 8'hFF;
            if (wrap) begin
              if (frame_cnt == BLINK_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          phase_cnt   <= '0;
          row_addr    <= 3'd0;
          row_addr_en <= 1'b1;
          col_out     <= 8'hFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_driver.sv
// Bench for led_matrix_driver: time-based display model checked every cycle,
// plus directed literal checks for scan, backpressure, blink, enable and reset.
module tb_led_matrix_driver;

  localparam int DWELL   = 4;
  localparam int BLANK   = 2;
  localparam int BLINK   = 2;
  localparam int ROW_P   = BLANK + DWELL;
  localparam int FRAME_P = 8 * ROW_P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] frame_data = '0;
  logic [63:0] blink_mask = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [2:0]  row_addr;
  logic        row_addr_en;
  logic [7:0]  col_out;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  led_matrix_driver #(
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK),
    .BLINK_FRAMES(BLINK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .frame_data (frame_data),
    .blink_mask (blink_mask),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .row_addr   (row_addr),
    .row_addr_en(row_addr_en),
    .col_out    (col_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Display model: position inside the scan is just elapsed cycles since enable.
  bit          m_scan = 1'b0;
  int          m_t = 0;
  bit          m_base = 1'b0;
  bit          m_pfull = 1'b0;
  bit          m_ready_old;
  logic [63:0] m_pf = '0;
  logic [63:0] m_pb = '0;
  logic [63:0] m_af = '0;
  logic [63:0] m_ab = '0;

  function automatic bit phase_at(input bit scan, input int t, input bit base);
    if (!scan) return base;
    return base ^ (((t / FRAME_P) / BLINK) % 2 == 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scan  = 1'b0;
      m_t     = 0;
      m_base  = 1'b0;
      m_pfull = 1'b0;
      m_pf    = '0;
      m_pb    = '0;
      m_af    = '0;
      m_ab    = '0;
    end else begin
      m_ready_old = !m_pfull;
      if (!m_scan) begin
        if (enable) begin
          m_scan = 1'b1;
          m_t    = 0;
        end
      end else if (!enable) begin
        m_base = phase_at(m_scan, m_t, m_base);
        m_scan = 1'b0;
      end else begin
        m_t++;
      end
      if (m_scan && (m_t % FRAME_P) == 0 && m_pfull) begin
        m_af    = m_pf;
        m_ab    = m_pb;
        m_pfull = 1'b0;
      end
      if (frame_valid && m_ready_old) begin
        m_pf    = frame_data;
        m_pb    = blink_mask;
        m_pfull = 1'b1;
      end
    end
  end

  bit         cmp_on = 1'b1;
  logic [2:0] e_row;
  logic       e_en;
  logic [7:0] e_col;
  logic       e_fs;
  bit         e_ph;

  always @(posedge clk) begin
    #1;
    if (cmp_on) begin
      e_ph = phase_at(m_scan, m_t, m_base);
      if (m_scan) begin
        e_row = 3'((m_t / ROW_P) % 8);
        e_fs  = (m_t % FRAME_P) == 0;
        if ((m_t % ROW_P) < BLANK) begin
          e_en  = 1'b1;
          e_col = 8'hFF;
        end else begin
          e_en = 1'b0;
          for (int c = 0; c < 8; c++) begin
            e_col[c] = !(m_af[e_row*8 + c] && !(m_ab[e_row*8 + c] && e_ph));
          end
        end
      end else begin
        e_row = 3'd0;
        e_en  = 1'b1;
        e_col = 8'hFF;
        e_fs  = 1'b0;
      end
      check("cycle", {frame_ready, row_addr, row_addr_en, col_out, frame_start},
            {!m_pfull, e_row, e_en, e_col, e_fs});
    end
  end

  // Row-address stability and dwell-length monitor over a chosen window.
  bit         stab_on = 1'b0;
  bit         s_prev_en = 1'b1;
  logic [2:0] s_prev_row = 3'd0;
  int         s_run = 0;

  always @(posedge clk) begin
    #1;
    if (stab_on) begin
      if (!row_addr_en) begin
        if (!s_prev_en) check("row_stable", row_addr, s_prev_row);
        s_run++;
      end else if (!s_prev_en) begin
        check("dwell_len", s_run, DWELL);
        s_run = 0;
      end
      s_prev_en  = row_addr_en;
      s_prev_row = row_addr;
    end else begin
      s_prev_en = 1'b1;
      s_run     = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] blink_exp [6] = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFE};
  int n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {frame_ready, row_addr, row_addr_en, col_out, frame_start},
          {1'b1, 3'd0, 1'b1, 8'hFF, 1'b0});
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic scan with a single frame loaded while idle.
    frame_data  = 64'h0000_0000_0000_0081;
    blink_mask  = '0;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    check("ready_after_accept", frame_ready, 1'b0);
    enable = 1'b1;
    @(posedge clk); #1;
    check("start_t0", {frame_start, frame_ready, row_addr_en}, 3'b111);
    @(posedge clk); #1;
    check("blank_t1", {frame_start, row_addr_en, col_out}, {1'b0, 1'b1, 8'hFF});
    @(posedge clk); #1;
    check("row0_drive", {row_addr, row_addr_en, col_out}, {3'd0, 1'b0, 8'h7E});
    repeat (6) @(posedge clk); #1;
    check("row1_drive", {row_addr, row_addr_en, col_out}, {3'd1, 1'b0, 8'hFF});
    repeat (40) @(posedge clk); #1;
    check("frame_start_48", frame_start, 1'b1);

    // Backpressure: A accepted mid-frame, B held until A is promoted.
    @(negedge clk);
    frame_data  = 64'h0000_0000_00F0_0000;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_data = 64'h0000_0000_003C_0000;
    check("ready_full", frame_ready, 1'b0);
    n = 0;
    while (frame_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_rise", frame_ready, 1'b1);
    @(negedge clk);
    frame_valid = 1'b0;
    repeat (13) @(posedge clk); #1;
    check("row2_A", {row_addr, row_addr_en, col_out}, {3'd2, 1'b0, 8'h0F});
    repeat (48) @(posedge clk); #1;
    check("row2_B", {row_addr, row_addr_en, col_out}, {3'd2, 1'b0, 8'hC3});

    // Asynchronous reset in the middle of a driven row.
    @(negedge clk);
    rst_n       = 1'b0;
    enable      = 1'b0;
    frame_valid = 1'b0;
    #1;
    check("rst_async", {frame_ready, row_addr, row_addr_en, col_out, frame_start},
          {1'b1, 3'd0, 1'b1, 8'hFF, 1'b0});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Blink: square 0 lit and blinking, two frames per half-period.
    frame_data  = 64'h1;
    blink_mask  = 64'h1;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    enable      = 1'b1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;
    check("blink_f0", {row_addr, row_addr_en, col_out}, {3'd0, 1'b0, blink_exp[0]});
    for (int k = 1; k < 6; k++) begin
      repeat (48) @(posedge clk); #1;
      check($sformatf("blink_f%0d", k), {row_addr, row_addr_en, col_out},
            {3'd0, 1'b0, blink_exp[k]});
    end

    // Enable drop during row 3 drive, then restart.
    repeat (18) @(posedge clk); #1;
    check("row3_drive", {row_addr, row_addr_en}, {3'd3, 1'b0});
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    check("drop_idle", {row_addr, row_addr_en, col_out, frame_start}, {3'd0, 1'b1, 8'hFF, 1'b0});
    @(negedge clk) enable = 1'b1;
    @(posedge clk); #1;
    check("restart", {frame_start, row_addr, row_addr_en}, {1'b1, 3'd0, 1'b1});

    // Three full frames under the stability monitor.
    #1 stab_on = 1'b1;
    repeat (3 * FRAME_P) @(posedge clk);
    #2 stab_on = 1'b0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
